// File: rtl/ccff_chain_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader_if
// Description : Valid/ready word stream feeding the CCFF chain loader.
//               master drives s_data/s_valid, slave returns s_ready.
// Ports       : s_data  [WORD_W] - configuration word, bit 0 shifted first
//               s_valid          - s_data holds a word
//               s_ready          - loader takes the word this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_chain_loader
// Description : Serialises configuration words onto the CCFF chain head,
//               LSB first, for exactly CHAIN_LEN bits, and accumulates the
//               parity of the bits returning on the chain tail.
// Ports       : prog_clk      - programming clock
//               pReset        - synchronous active-high reset
//               start         - begin a load (honoured only when idle)
//               s_if          - word stream (slave side)
//               ccff_head     - serial data into the chain
//               ccff_shift_en - chain captures on the next edge
//               ccff_tail     - serial data out of the chain
//               busy          - load in progress
//               done          - one-cycle completion pulse
//               tail_parity   - XOR of tail samples taken while shifting
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  wire logic          prog_clk,
  input  wire logic          pReset,
  input  wire logic          start,
  ccff_chain_loader_if.slave s_if,
  output logic               ccff_head,
  output logic               ccff_shift_en,
  input  wire logic          ccff_tail,
  output logic               busy,
  output logic               done,
  output logic               tail_parity
);

  localparam int                WB_W      = $clog2(WORD_W);
  localparam logic [WB_W-1:0]   WB_LAST   = WB_W'(WORD_W - 1);
  localparam logic [WB_W-1:0]   WB_ONE    = WB_W'(1);
  localparam logic [CNT_W-1:0]  BITS_INIT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  BITS_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WB_W-1:0]   word_bit_q, word_bit_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic              parity_q, parity_d;

  logic last_bit;   // current shift delivers the final chain bit
  logic word_end;   // current shift delivers the final bit of sreg

  assign last_bit = (bits_left_q == BITS_ONE);
  assign word_end = (word_bit_q == WB_LAST);

  // Head is a straight tap of the shift register so the chain sees a clean
  // flop output; sreg is cleared on reset, which makes the head read 0.
  assign ccff_head     = sreg_q[0];
  assign ccff_shift_en = (state_q == SHIFT);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign tail_parity   = parity_q;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      word_bit_q  <= '0;
      bits_left_q <= '0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      word_bit_q  <= word_bit_d;
      bits_left_q <= bits_left_d;
      parity_q    <= parity_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    word_bit_d   = word_bit_q;
    bits_left_d  = bits_left_q;
    parity_d     = parity_q;
    s_if.s_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          bits_left_d = BITS_INIT;
          parity_d    = 1'b0;
        end
      end

      LOAD: begin
        s_if.s_ready = 1'b1;
        if (s_if.s_valid) begin
          sreg_d     = s_if.s_data;
          word_bit_d = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        sreg_d   = sreg_q >> 1;
        parity_d = parity_q ^ ccff_tail;
        if (bits_left_q != '0) bits_left_d = bits_left_q - BITS_ONE;
        if (!word_end)         word_bit_d  = word_bit_q + WB_ONE;

        // The last chain bit wins over a word boundary: leftover word bits
        // are dropped and no further word is requested.
        if (last_bit) begin
          state_d = DONE;
        end else if (word_end) begin
          // Request the next word in the same cycle so a waiting word
          // streams in without a bubble.
          s_if.s_ready = 1'b1;
          if (s_if.s_valid) begin
            sreg_d     = s_if.s_data;
            word_bit_d = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Serializes configuration words from the bitstream path onto the configuration flip-flop (CCFF) chain head of the grid tiles. Runs on the programming clock, accepts words through a valid/ready handshake and shifts exactly `CHAIN_LEN` bits into `ccff_head`, LSB first. Asserts a chain shift enable while shifting. Accumulates the parity of the bits returning on `ccff_tail` so the secured-bitstream checker can compare it against the expected readback.

## Interface
- `WORD_W`, 32: width of an input configuration word (≥2).
- `CHAIN_LEN`, 1024: total CCFF bits in the chain (≥1).
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: width of the bit counter.

- `prog_clk` in 1: programming clock. Everything is synchronous to it.
- `pReset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a load. Sampled only in IDLE.
- `s_data` in WORD_W: configuration word. Bit 0 is shifted first.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: the loader accepts a word on this cycle when `s_valid` is also high.
- `ccff_head` out 1: serial data into the chain.
- `ccff_shift_en` out 1: chain flip-flops capture on the next `prog_clk` edge when this is high.
- `ccff_tail` in 1: serial data out of the chain.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the load is complete.
- `tail_parity` out 1: XOR of every `ccff_tail` sample taken while `ccff_shift_en` was high. Held stable from `done` until the next `start`.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE**:
  - `start=1` → LOAD.
  - On that transition: `bits_left` ← `CHAIN_LEN`, `tail_parity` ← 0.
  - `start` is ignored in every other state.
- **LOAD**:
  - `s_ready=1`.
  - On `s_valid`: load `sreg` ← `s_data`, `word_bit` ← 0, go to SHIFT.
  - Otherwise stay in LOAD with `ccff_shift_en=0`. This is a bubble; the chain holds its contents.
- **SHIFT** (each cycle):
  - `ccff_head=sreg[0]` and `ccff_shift_en=1`.
  - On the clock edge: `sreg` ← `sreg>>1`, `word_bit`++, `bits_left`--, `tail_parity` ^= `ccff_tail`.
- **Exits from SHIFT**:
  - When `bits_left==1` this is the last chain bit. Go to DONE. Any remaining bits of the current word are discarded.
  - Otherwise, when `word_bit==WORD_W-1`, `s_ready=1` in this same cycle. If `s_valid=1`, load the new word and stay in SHIFT, so there is no bubble. If not, go to LOAD.
- **DONE**: `done=1` for one cycle, then go to IDLE. Words offered after the final load are not accepted.
- `s_ready` is a combinational decode of state, `word_bit` and `bits_left`. It must not depend on `s_valid`.
- **Counters**: `word_bit` is `$clog2(WORD_W)` bits and never wraps past `WORD_W-1`. `bits_left` is `CNT_W` bits and never underflows.
- **Mid-operation reset**: `pReset` at any cycle forces IDLE on the next edge. The chain contents are then undefined and software must restart.
- **Reset values**: `s_ready=0`, `ccff_head=0`, `ccff_shift_en=0`, `busy=0`, `done=0`, `tail_parity=0`.

## Timing
- `start` is sampled at edge N. `s_ready` is high from cycle N+1.
- A word is accepted at edge M. The first bit is on `ccff_head` with `ccff_shift_en=1` during cycle M+1.
- With `s_valid` held high, `ccff_shift_en` is high for exactly `CHAIN_LEN` consecutive cycles. `done` pulses the cycle after the last shift.
- Each cycle `s_valid` is low while a word is needed inserts exactly one cycle with `ccff_shift_en=0`. The total number of shift cycles is always `CHAIN_LEN`.
- `ccff_head` and `ccff_shift_en` are driven directly from state and `sreg`, with no logic beyond the `sreg[0]` tap.
- `tail_parity` is final on the `done` cycle.

## Test plan
- **Streaming**: `WORD_W=32`, `CHAIN_LEN=70`, `s_valid` always high, start at edge 0. Required:
  - `s_ready` handshakes at edges 1, 33 and 65.
  - `ccff_shift_en` high in cycles 2–71.
  - `done` in cycle 72.
  - Bits 6–31 of word 3 never appear on `ccff_head`.
- **Bubble**: same setup with `s_valid` low for 3 cycles before word 2. Required: exactly 3 cycles of `ccff_shift_en=0` mid-stream, still 70 shift cycles total, `done` 3 cycles later than in the streaming case.
- **Loopback parity**: connect the bench's 70-bit shift register between `ccff_head` and `ccff_tail`, preloaded with a pattern of 5 ones. Load all-zero words. Required: `tail_parity=1` at `done`.
- **Ignored start**: pulse `start` during SHIFT. Required: no effect on counters and `tail_parity`.
- **Single-bit chain**: `CHAIN_LEN=1`, word `0x1`. Required: one shift cycle with `ccff_head=1`, then `done`.
- **Mid-load reset**: `pReset` asserted after 40 shifts. Required: next cycle all outputs at their reset values. A fresh `start` then completes a full 70-bit load.
